// File: rtl/time_set_ctrl.sv
// Keypad time-entry sequencer: captures the running time into a shadow copy, edits it
// digit by digit with BCD range checks, then commits it to the counter via req/ack.
module time_set_ctrl #(
    parameter int CLK_HZ     = 1000,
    parameter int TIMEOUT_S  = 10,
    parameter int BLINK_HALF = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_mode,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic [23:0] cur_time,
    output logic        load_req,
    output logic [23:0] load_time,
    input  logic        load_ack,
    output logic        edit_active,
    output logic [2:0]  edit_pos,
    output logic [5:0]  blink_mask,
    output logic        key_err
);
    localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_EDIT, S_COMMIT} state_t;

    state_t            state_q, state_d;
    logic              set_mode_q;
    logic [23:0]       shadow_q, shadow_d;
    logic [2:0]        pos_q, pos_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [5:0]        sec_q, sec_d;
    logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d;
    logic              blk_off_q, blk_off_d;
    logic              load_req_q, load_req_d;
    logic [23:0]       load_time_q, load_time_d;
    logic              edit_active_q, edit_active_d;
    logic [5:0]        blink_mask_q, blink_mask_d;
    logic              key_err_q, key_err_d;

    logic [3:0]        limit;
    logic              key_ok;
    logic              tick;
    logic [4:0]        dig_lsb;

    // Digit 0 (h_ten) sits in the top nibble.
    assign dig_lsb = 5'd20 - {pos_q, 2'b00};

    always_comb begin
        case (pos_q)
            3'd0:    limit = 4'd2;
            3'd1:    limit = (shadow_q[23:20] == 4'd2) ? 4'd3 : 4'd9;
            3'd2:    limit = 4'd5;
            3'd4:    limit = 4'd5;
            default: limit = 4'd9;
        endcase
    end

    assign key_ok = (key_digit <= limit);
    assign tick   = (div_q == DIV_W'(CLK_HZ - 1));

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        pos_d       = pos_q;
        div_d       = div_q;
        sec_d       = sec_q;
        blk_cnt_d   = blk_cnt_q;
        blk_off_d   = blk_off_q;
        load_req_d  = load_req_q;
        load_time_d = load_time_q;
        key_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (set_mode && !set_mode_q) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                shadow_d  = cur_time;
                pos_d     = 3'd0;
                div_d     = '0;
                sec_d     = '0;
                blk_cnt_d = '0;
                blk_off_d = 1'b0;
                state_d   = S_EDIT;
            end
            S_EDIT: begin
                if (blk_cnt_q == BLK_W'(BLINK_HALF - 1)) begin
                    blk_cnt_d = '0;
                    blk_off_d = ~blk_off_q;
                end else begin
                    blk_cnt_d = blk_cnt_q + BLK_W'(1);
                end
                if (tick) begin
                    div_d = '0;
                    sec_d = sec_q + 6'd1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end

                if (key_valid) begin
                    div_d = '0;
                    sec_d = '0;
                    if (key_ok) begin
                        shadow_d[dig_lsb +: 4] = key_digit;
                        // Entering a 2x hour must not leave an illegal 24..29.
                        if (pos_q == 3'd0 && key_digit == 4'd2 && shadow_q[19:16] > 4'd3)
                            shadow_d[19:16] = 4'd3;
                        if (pos_q == 3'd5) begin
                            state_d = S_COMMIT;
                        end else begin
                            pos_d     = pos_q + 3'd1;
                            blk_cnt_d = '0;
                            blk_off_d = 1'b0;
                        end
                    end else begin
                        key_err_d = 1'b1;
                    end
                end

                if (state_d == S_EDIT && !set_mode)
                    state_d = S_COMMIT;
                else if (state_d == S_EDIT && !key_valid && tick && (sec_q + 6'd1 == 6'(TIMEOUT_S)))
                    state_d = S_IDLE;

                if (state_d == S_COMMIT) begin
                    load_req_d  = 1'b1;
                    load_time_d = shadow_d;
                end
            end
            S_COMMIT: begin
                if (load_ack) begin
                    load_req_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        edit_active_d = (state_d != S_IDLE);
        blink_mask_d  = (state_d == S_EDIT && blk_off_d) ? (6'b100000 >> pos_d) : 6'b000000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            // Reset high so a level already present at release is not seen as an edge.
            set_mode_q    <= 1'b1;
            shadow_q      <= '0;
            pos_q         <= '0;
            div_q         <= '0;
            sec_q         <= '0;
            blk_cnt_q     <= '0;
            blk_off_q     <= 1'b0;
            load_req_q    <= 1'b0;
            load_time_q   <= '0;
            edit_active_q <= 1'b0;
            blink_mask_q  <= '0;
            key_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            set_mode_q    <= set_mode;
            shadow_q      <= shadow_d;
            pos_q         <= pos_d;
            div_q         <= div_d;
            sec_q         <= sec_d;
            blk_cnt_q     <= blk_cnt_d;
            blk_off_q     <= blk_off_d;
            load_req_q    <= load_req_d;
            load_time_q   <= load_time_d;
            edit_active_q <= edit_active_d;
            blink_mask_q  <= blink_mask_d;
            key_err_q     <= key_err_d;
        end
    end

    assign load_req    = load_req_q;
    assign load_time   = load_time_q;
    assign edit_active = edit_active_q;
    assign edit_pos    = pos_q;
    assign blink_mask  = blink_mask_q;
    assign key_err     = key_err_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: a cycle-level behavioural model checked every cycle,
// plus directed keypad scenarios with hand-computed expectations.
module tb_time_set_ctrl;
    localparam int CLK_HZ     = 10;
    localparam int TIMEOUT_S  = 2;
    localparam int BLINK_HALF = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        set_mode = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_digit = 4'd0;
    logic [23:0] cur_time = 24'h0;
    logic        load_ack = 1'b0;
    logic        load_req;
    logic [23:0] load_time;
    logic        edit_active;
    logic [2:0]  edit_pos;
    logic [5:0]  blink_mask;
    logic        key_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    time_set_ctrl #(.CLK_HZ(CLK_HZ), .TIMEOUT_S(TIMEOUT_S), .BLINK_HALF(BLINK_HALF)) dut (
        .clk(clk), .rst(rst), .set_mode(set_mode), .key_valid(key_valid),
        .key_digit(key_digit), .cur_time(cur_time), .load_req(load_req),
        .load_time(load_time), .load_ack(load_ack), .edit_active(edit_active),
        .edit_pos(edit_pos), .blink_mask(blink_mask), .key_err(key_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("[TB] FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 capture, 2 edit, 3 commit
    int          m_mode = 0;
    bit          m_prev_sm = 1'b1;
    int          m_sh[6];
    int          m_pos = 0;
    int          m_quiet = 0;
    int          m_bn = 0;
    bit          m_req = 0;
    logic [23:0] m_ltime = 24'h0;
    bit          m_err = 0;

    function automatic int lim(input int p, input int hten);
        case (p)
            0: return 2;
            1: return (hten == 2) ? 3 : 9;
            2: return 5;
            4: return 5;
            default: return 9;
        endcase
    endfunction

    function automatic logic [23:0] pack_sh();
        logic [23:0] v = 24'h0;
        for (int i = 0; i < 6; i++) v = (v << 4) | 24'(m_sh[i]);
        return v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_prev_sm = 1'b1; m_pos = 0; m_quiet = 0; m_bn = 0;
        m_req = 0; m_ltime = 24'h0; m_err = 0;
        for (int i = 0; i < 6; i++) m_sh[i] = 0;
    endtask

    task automatic model_step();
        int kd;
        m_err = 0;
        case (m_mode)
            0: if (set_mode && !m_prev_sm) m_mode = 1;
            1: begin
                for (int i = 0; i < 6; i++) m_sh[i] = int'((cur_time >> (20 - 4 * i)) & 24'hF);
                m_pos = 0; m_quiet = 0; m_bn = 0; m_mode = 2;
            end
            2: begin
                m_quiet++;
                m_bn++;
                if (key_valid) begin
                    kd = int'(key_digit);
                    m_quiet = 0;
                    if (kd <= lim(m_pos, m_sh[0])) begin
                        m_sh[m_pos] = kd;
                        if (m_pos == 0 && kd == 2 && m_sh[1] > 3) m_sh[1] = 3;
                        if (m_pos == 5) m_mode = 3;
                        else begin m_pos++; m_bn = 0; end
                    end else begin
                        m_err = 1;
                    end
                end
                if (m_mode == 2 && !set_mode) m_mode = 3;
                else if (m_mode == 2 && m_quiet >= CLK_HZ * TIMEOUT_S) m_mode = 0;
                if (m_mode == 3) begin m_req = 1; m_ltime = pack_sh(); end
            end
            default: if (load_ack) begin m_req = 0; m_mode = 0; end
        endcase
        m_prev_sm = set_mode;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                chk("m_edit_active", 32'(edit_active), 32'(m_mode != 0));
                chk("m_edit_pos", 32'(edit_pos), 32'(m_pos));
                chk("m_key_err", 32'(key_err), 32'(m_err));
                chk("m_load_req", 32'(load_req), 32'(m_req));
                if (m_req) chk("m_load_time", 32'(load_time), 32'(m_ltime));
                chk("m_blink_mask", 32'(blink_mask),
                    (m_mode == 2 && ((m_bn / BLINK_HALF) % 2 == 1)) ? 32'(6'b100000 >> m_pos) : 32'd0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // All tasks start and end at a falling edge.
    task automatic press(input int d);
        key_valid = 1'b1; key_digit = 4'(d);
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic enter(input logic [23:0] t);
        cur_time = t; set_mode = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic ack();
        load_ack = 1'b1;
        @(negedge clk);
        load_ack = 1'b0;
        chk("ack_load_req", 32'(load_req), 32'd0);
        chk("ack_edit_active", 32'(edit_active), 32'd0);
    endtask

    task automatic leave_idle();
        set_mode = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kseq[6] = '{1, 8, 3, 0, 4, 5};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_load_req", 32'(load_req), 32'd0);
        chk("reset_load_time", 32'(load_time), 32'd0);
        chk("reset_edit_active", 32'(edit_active), 32'd0);
        chk("reset_blink", 32'(blink_mask), 32'd0);
        $display("[TB] reset state checked");

        // Full entry.
        enter(24'h123456);
        chk("t1_edit_active", 32'(edit_active), 32'd1);
        chk("t1_pos0", 32'(edit_pos), 32'd0);
        for (int i = 0; i < 6; i++) press(kseq[i]);
        chk("t1_load_req", 32'(load_req), 32'd1);
        chk("t1_load_time", 32'(load_time), 32'h183045);
        $display("[TB] full entry: load_time=%06h", load_time);
        ack();
        leave_idle();

        // Range checks.
        enter(24'h000000);
        press(3);
        chk("t2_err_pos0", 32'(key_err), 32'd1);
        chk("t2_pos_stay", 32'(edit_pos), 32'd0);
        press(2);
        chk("t2_no_err", 32'(key_err), 32'd0);
        chk("t2_pos1", 32'(edit_pos), 32'd1);
        press(4);
        chk("t2_err_pos1", 32'(key_err), 32'd1);
        chk("t2_pos1_stay", 32'(edit_pos), 32'd1);
        press(3);
        chk("t2_pos2", 32'(edit_pos), 32'd2);
        set_mode = 1'b0;
        @(negedge clk);
        chk("t2_load_time", 32'(load_time), 32'h230000);
        $display("[TB] range check: load_time=%06h", load_time);
        ack();

        // h_one clamp and blink phase.
        enter(24'h190000);
        press(2);
        chk("t3_pos1", 32'(edit_pos), 32'd1);
        repeat (3) @(negedge clk);
        chk("t3_blink_vis", 32'(blink_mask), 32'd0);
        @(negedge clk);
        chk("t3_blink_off", 32'(blink_mask), 32'h10);
        set_mode = 1'b0;
        @(negedge clk);
        chk("t3_load_time", 32'(load_time), 32'h230000);
        $display("[TB] clamp: load_time=%06h", load_time);
        ack();

        // Partial edit; last key coincides with set_mode fall.
        enter(24'h221530);
        press(0);
        key_valid = 1'b1; key_digit = 4'd7; set_mode = 1'b0;
        @(negedge clk);
        key_valid = 1'b0;
        chk("t4_load_req", 32'(load_req), 32'd1);
        chk("t4_load_time", 32'(load_time), 32'h071530);
        $display("[TB] partial edit: load_time=%06h", load_time);
        ack();

        // Timeout, then no re-entry while set_mode stays high.
        enter(24'h000000);
        repeat (CLK_HZ * TIMEOUT_S - 1) @(negedge clk);
        chk("t5_before_timeout", 32'(edit_active), 32'd1);
        @(negedge clk);
        chk("t5_timeout_idle", 32'(edit_active), 32'd0);
        chk("t5_no_req", 32'(load_req), 32'd0);
        repeat (5) @(negedge clk);
        chk("t5_no_reentry", 32'(edit_active), 32'd0);
        $display("[TB] timeout: edit_active=%0d", edit_active);
        leave_idle();

        // Handshake stall, then async reset mid-commit.
        enter(24'h123456);
        set_mode = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            chk("t6_stall_req", 32'(load_req), 32'd1);
            chk("t6_stall_time", 32'(load_time), 32'h123456);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_load_req", 32'(load_req), 32'd0);
        chk("t6_rst_load_time", 32'(load_time), 32'd0);
        chk("t6_rst_edit_active", 32'(edit_active), 32'd0);
        chk("t6_rst_edit_pos", 32'(edit_pos), 32'd0);
        $display("[TB] async reset during stall: load_req=%0d", load_req);
        set_mode = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t7_high_at_release", 32'(edit_active), 32'd0);
        leave_idle();
        enter(24'h000000);
        chk("t7_entry_after_edge", 32'(edit_active), 32'd1);
        $display("[TB] reset-release with set_mode high checked");
        set_mode = 1'b0;
        @(negedge clk);
        ack();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
